// File: rtl/rule_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rule_write_ctrl
// Purpose  : Writer side of the TCAM rule memory. It handles write, delete and
//            flush requests, runs a clearing sweep after reset, and keeps a
//            per-entry valid vector. Define RULE_VERIFY_EN to read each
//            write/delete back and check it.
// Revision : 1.0 - initial release
// ============================================================================
module rule_write_ctrl #(
  parameter int MAX_RULE = 64,
  parameter int KEY_LEN  = 32,
  parameter int ADDR_W   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [KEY_LEN-1:0]  req_rule,
  output logic                done_valid,
  output logic                done_err,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [KEY_LEN-1:0]  mem_wdata,
  output logic [ADDR_W-1:0]   mem_raddr,
  input  logic [KEY_LEN-1:0]  mem_rdata,
  output logic [MAX_RULE-1:0] entry_valid,
  output logic                busy
);

  localparam logic [2:0] c_INIT   = 3'd0;
  localparam logic [2:0] c_IDLE   = 3'd1;
  localparam logic [2:0] c_WRITE  = 3'd2;
  localparam logic [2:0] c_SWEEP  = 3'd3;
  localparam logic [2:0] c_VERIFY = 3'd4;
  localparam logic [2:0] c_RESP   = 3'd5;

  localparam logic [ADDR_W:0] c_MAX = (ADDR_W+1)'(MAX_RULE);

  logic [2:0]        r_state;
  logic [ADDR_W:0]   r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_del;
  logic              w_accept;
  logic              w_bad;

  assign w_accept = (r_state == c_IDLE) && req_valid && req_ready;
  assign w_bad    = (req_op == 2'b11) || ({1'b0, req_addr} >= c_MAX);

`ifndef RULE_VERIFY_EN
  logic w_unused_rdata;
  assign w_unused_rdata = ^mem_rdata;
  assign mem_raddr      = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_INIT;
      r_ptr       <= '0;
      r_addr      <= '0;
      r_del       <= 1'b0;
      req_ready   <= 1'b0;
      done_valid  <= 1'b0;
      done_err    <= 1'b0;
      mem_we      <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      entry_valid <= '0;
      busy        <= 1'b0;
`ifdef RULE_VERIFY_EN
      mem_raddr   <= '0;
`endif
    end else begin
      case (r_state)
        // The pointer runs one past the last entry so the final write stays
        // visible for a full cycle before mem_we drops.
        c_INIT, c_SWEEP: begin
          if (r_ptr == c_MAX) begin
            mem_we <= 1'b0;
            if (r_state == c_INIT) begin
              r_state   <= c_IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              r_state     <= c_RESP;
              done_valid  <= 1'b1;
              done_err    <= 1'b0;
              entry_valid <= '0;
            end
          end else begin
            mem_we    <= 1'b1;
            mem_waddr <= r_ptr[ADDR_W-1:0];
            mem_wdata <= '0;
            r_ptr     <= r_ptr + 1'b1;
            busy      <= 1'b1;
          end
        end

        c_IDLE: begin
          if (w_accept) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (w_bad) begin
              r_state    <= c_RESP;
              done_valid <= 1'b1;
              done_err   <= 1'b1;
            end else if (req_op == 2'b10) begin
              r_state   <= c_SWEEP;
              mem_we    <= 1'b1;
              mem_waddr <= '0;
              mem_wdata <= '0;
              r_ptr     <= {{ADDR_W{1'b0}}, 1'b1};
            end else begin
              r_state   <= c_WRITE;
              mem_we    <= 1'b1;
              mem_waddr <= req_addr;
              mem_wdata <= req_op[0] ? '0 : req_rule;
              r_addr    <= req_addr;
              r_del     <= req_op[0];
            end
          end
        end

        c_WRITE: begin
          mem_we <= 1'b0;
`ifdef RULE_VERIFY_EN
          mem_raddr <= r_addr;
          r_state   <= c_VERIFY;
`else
          entry_valid[r_addr] <= !r_del;
          done_valid          <= 1'b1;
          done_err            <= 1'b0;
          r_state             <= c_RESP;
`endif
        end

`ifdef RULE_VERIFY_EN
        // mem_wdata still holds the value just written, so it is the reference.
        c_VERIFY: begin
          entry_valid[r_addr] <= !r_del && (mem_rdata == mem_wdata);
          done_valid          <= 1'b1;
          done_err            <= (mem_rdata != mem_wdata);
          r_state             <= c_RESP;
        end
`endif

        c_RESP: begin
          done_valid <= 1'b0;
          done_err   <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          r_state    <= c_IDLE;
        end

        default: begin
          r_state <= c_INIT;
          r_ptr   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rule_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rule_write_ctrl
// Purpose  : Directed self-checking bench for rule_write_ctrl (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rule_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [5:0]  req_addr = '0;
  logic [31:0] req_rule = '0;
  logic        done_valid;
  logic        done_err;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [5:0]  mem_raddr;
  logic [31:0] mem_rdata = '0;
  logic [63:0] entry_valid;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  rule_write_ctrl #(.MAX_RULE(64), .KEY_LEN(32), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_rule(req_rule),
    .done_valid(done_valid), .done_err(done_err),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .entry_valid(entry_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request in the current cycle T; returns in cycle T+1.
  task automatic do_req(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] rule);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_rule  = rule;
    tick();
    req_valid = 1'b0;
    req_rule  = 32'hDEAD_BEEF;
  endtask

  task automatic init_check(input string tag);
    int  we_cnt = 0;
    bit  bad = 1'b0;
    bit  done_seen = 1'b0;
    bit  rdy = 1'b0;
    for (int i = 0; i < 200 && !rdy; i++) begin
      tick();
      if (mem_we) begin
        if (mem_waddr != we_cnt[5:0] || mem_wdata != 32'd0) bad = 1'b1;
        we_cnt++;
      end
      if (done_valid) done_seen = 1'b1;
      if (req_ready) rdy = 1'b1;
    end
    chk({tag, "_we_count"}, 64'(we_cnt), 64'd64);
    chk({tag, "_sweep_seq"}, 64'(bad), 64'd0);
    chk({tag, "_ready"}, 64'(rdy), 64'd1);
    chk({tag, "_no_done"}, 64'(done_seen), 64'd0);
    chk({tag, "_entry_valid"}, entry_valid, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int  we_cnt;
    int  done_cnt;
    int  done_at;
    bit  bad;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_done", 64'(done_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ev", entry_valid, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    init_check("init");

    // Write addr 5
    do_req(2'b00, 6'd5, 32'hC0A8_0001);
    chk("wr_we", 64'(mem_we), 64'd1);
    chk("wr_addr", 64'(mem_waddr), 64'd5);
    chk("wr_data", 64'(mem_wdata), 64'hC0A8_0001);
    chk("wr_busy", 64'(busy), 64'd1);
    chk("wr_no_early_done", 64'(done_valid), 64'd0);
    tick();
    chk("wr_done", 64'(done_valid), 64'd1);
    chk("wr_err", 64'(done_err), 64'd0);
    chk("wr_ev", entry_valid, 64'h20);
    chk("wr_we_off", 64'(mem_we), 64'd0);
    tick();
    chk("wr_ready", 64'(req_ready), 64'd1);
    chk("wr_done_pulse", 64'(done_valid), 64'd0);

    // Delete addr 5
    do_req(2'b01, 6'd5, 32'h1234_5678);
    chk("del_we", 64'(mem_we), 64'd1);
    chk("del_addr", 64'(mem_waddr), 64'd5);
    chk("del_data", 64'(mem_wdata), 64'd0);
    tick();
    chk("del_done", 64'(done_valid), 64'd1);
    chk("del_err", 64'(done_err), 64'd0);
    chk("del_ev", entry_valid, 64'd0);
    tick();

    // Write 7, then reserved op must leave it untouched
    do_req(2'b00, 6'd7, 32'hAAAA_5555);
    tick(); tick();
    do_req(2'b11, 6'd9, 32'h0000_0001);
    chk("err_we", 64'(mem_we), 64'd0);
    chk("err_done", 64'(done_valid), 64'd1);
    chk("err_flag", 64'(done_err), 64'd1);
    chk("err_ev", entry_valid, 64'h80);
    tick();
    chk("err_ready", 64'(req_ready), 64'd1);
    chk("err_done_pulse", 64'(done_valid), 64'd0);

    // Delete a free entry is legal; rewrite a live entry keeps it valid
    do_req(2'b01, 6'd10, 32'h0);
    tick();
    chk("delfree_err", 64'(done_err), 64'd0);
    chk("delfree_ev", entry_valid, 64'h80);
    tick();
    do_req(2'b00, 6'd7, 32'h0BAD_F00D);
    chk("rewr_data", 64'(mem_wdata), 64'h0BAD_F00D);
    tick();
    chk("rewr_ev", entry_valid, 64'h80);
    tick();

    // Boundary entries then flush
    do_req(2'b00, 6'd0, 32'h1111_1111);
    tick(); tick();
    do_req(2'b00, 6'd63, 32'h6363_6363);
    tick();
    chk("edge_ev", entry_valid, 64'h8000_0000_0000_0081);
    tick();
    do_req(2'b10, 6'd0, 32'h0);
    we_cnt = 0; done_cnt = 0; done_at = 0; bad = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      if (mem_we) begin
        if (mem_waddr != we_cnt[5:0] || mem_wdata != 32'd0) bad = 1'b1;
        we_cnt++;
      end
      if (done_valid) begin
        done_cnt++;
        done_at = k;
        if (done_err) bad = 1'b1;
        if (entry_valid != 64'd0) bad = 1'b1;
      end
      tick();
    end
    chk("flush_we_count", 64'(we_cnt), 64'd64);
    chk("flush_done_count", 64'(done_cnt), 64'd1);
    chk("flush_done_time", 64'(done_at), 64'd65);
    chk("flush_seq", 64'(bad), 64'd0);
    chk("flush_ev", entry_valid, 64'd0);
    chk("flush_ready", 64'(req_ready), 64'd1);

    // Reset in the middle of a flush
    do_req(2'b00, 6'd3, 32'h3333_3333);
    tick(); tick();
    do_req(2'b10, 6'd0, 32'h0);
    repeat (20) tick();
    chk("midflush_addr", 64'(mem_waddr), 64'd20);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 64'(mem_we), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ev", entry_valid, 64'd0);
    chk("midrst_addr", 64'(mem_waddr), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    init_check("reinit");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach end, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
